// File: rtl/offchip_mem_bridge_pkg.sv
// Shared definitions for the off-chip memory bridge: FSM state encoding,
// word/beat width constants and the beat-counter width helper.
package offchip_mem_bridge_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned TIMER_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } bridge_state_e;

  // Beat counter width; at least one bit even for a single-beat line.
  function automatic int unsigned beat_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/offchip_beat_timer.sv
// Per-beat wait counter for the off-chip memory bridge.
// Ports: clk, rst (async, active-high); clr zeroes the count; en counts one
// wait cycle; expired_c is high during the wait cycle that reaches the limit.
module offchip_beat_timer
  import offchip_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [TIMER_W-1:0] count_q;

  // Wait-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + TIMER_W'(1);
    end
  end

  // Fires in the last allowed wait cycle so the request drops right after it.
  assign expired_c = en && (count_q == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/offchip_mem_bridge.sv
// Off-chip memory bridge: turns whole-line cache refill/write-back requests
// into sequential 32-bit beats on a word-wide external memory port.
// Ports: cache side offchip_mem_* (level read/write enables, line address,
// line write data, line read data, ready pulse, busy flags, error);
// memory side mem_* (req/we/addr/wdata out, rdata/ack in).
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 32
`endif

module offchip_mem_bridge
  import offchip_mem_bridge_pkg::*;
#(
  parameter int unsigned LINE_BYTES     = `CACHE_LINE_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    offchip_mem_read_en,
  input  logic                    offchip_mem_write_en,
  input  logic [31:0]             offchip_mem_addr,
  input  logic [LINE_BYTES*8-1:0] offchip_mem_wdata,
  output logic [LINE_BYTES*8-1:0] offchip_mem_data,
  output logic                    offchip_mem_ready,
  output logic                    offchip_mem_read_busy,
  output logic                    offchip_mem_write_busy,
  output logic                    offchip_mem_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ack
);

  localparam int unsigned BEATS  = LINE_BYTES / WORD_BYTES;
  localparam int unsigned BW     = beat_w(BEATS);
  localparam int unsigned OFFS_W = $clog2(LINE_BYTES);

  bridge_state_e               state_q, state_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic                        err_q, err_d;
  logic [31:0]                 base_q, base_d;
  logic [BEATS-1:0][WORD_W-1:0] wbuf_q;
  logic [BEATS-1:0][WORD_W-1:0] line_q, line_d;
  logic [BEATS-1:0][WORD_W-1:0] data_q;
  logic                        beat_ack;
  logic                        expired_c;
  logic                        unused_addr_bits;

  assign unused_addr_bits = ^offchip_mem_addr[OFFS_W-1:0];

  // Memory-side decode from registered state and beat counter
  assign mem_req   = (state_q == RD) || (state_q == WR);
  assign mem_we    = (state_q == WR);
  // OR instead of add: the base has its offset bits cleared, so no carry out of the line
  assign mem_addr  = mem_req ? (base_q | 32'({beat_q, 2'b00})) : '0;
  assign mem_wdata = mem_we ? wbuf_q[beat_q] : '0;
  assign beat_ack  = mem_req && mem_ack;

  offchip_beat_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (!mem_req || mem_ack),
    .en       (mem_req && !mem_ack),
    .expired_c(expired_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, beat counter, error flag and line buffer update
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    base_d  = base_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (offchip_mem_write_en) begin
          state_d = WR;
          base_d  = {offchip_mem_addr[31:OFFS_W], OFFS_W'(0)};
          beat_d  = '0;
          err_d   = 1'b0;
        end else if (offchip_mem_read_en) begin
          state_d = RD;
          base_d  = {offchip_mem_addr[31:OFFS_W], OFFS_W'(0)};
          beat_d  = '0;
          err_d   = 1'b0;
          // Words never received on a timeout must read back as zero
          line_d  = '0;
        end
      end
      RD, WR: begin
        if (beat_ack) begin
          if (state_q == RD) begin
            line_d[beat_q] = mem_rdata;
          end
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(BEATS - 1)) begin
            state_d = DONE;
          end
        end else if (expired_c) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered cache-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q                 <= '0;
      err_q                  <= 1'b0;
      base_q                 <= '0;
      wbuf_q                 <= '0;
      line_q                 <= '0;
      data_q                 <= '0;
      offchip_mem_ready      <= 1'b0;
      offchip_mem_err        <= 1'b0;
      offchip_mem_read_busy  <= 1'b0;
      offchip_mem_write_busy <= 1'b0;
    end else begin
      beat_q <= beat_d;
      err_q  <= err_d;
      base_q <= base_d;
      line_q <= line_d;
      if ((state_q == IDLE) && (state_d == WR)) begin
        wbuf_q <= offchip_mem_wdata;
      end
      // Visible read line only changes when a read completes
      if ((state_q == RD) && (state_d == DONE)) begin
        data_q <= line_d;
      end
      offchip_mem_ready      <= (state_d == DONE);
      offchip_mem_err        <= (state_d == DONE) && err_d;
      offchip_mem_read_busy  <= (state_d == RD) || ((state_d == DONE) && (state_q == RD));
      offchip_mem_write_busy <= (state_d == WR) || ((state_d == DONE) && (state_q == WR));
    end
  end

  assign offchip_mem_data = data_q;

endmodule
